// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and data ports, data first with fetch starvation guard.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts a transaction stuck without mem_ready.
module unified_mem_arbiter #(
   parameter int WIDTH = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_addr,
   output logic [WIDTH-1:0] i_rdata,
   output logic             i_valid,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_valid,
   output logic             stall_f,
   output logic             stall_m,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic             err
);
   localparam logic [1:0] IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
   logic [1:0] state;
   logic [SW-1:0] streak;
   logic heldWe;
   logic [WIDTH-1:0] heldAddr, heldWdata, readData;
   logic busy, abort, done, grantD, grantI;
   assign busy = state != IDLE;
   // Data wins unless fetch has already lost STARVE_LIMIT times in a row
   assign grantD = !busy && d_req && (!i_req || streak < LIMIT);
   assign grantI = !busy && i_req && !grantD;
   assign done = busy && (mem_ready || abort);
   assign readData = mem_ready ? mem_rdata : '0;
   assign i_valid = done && state == BUSY_I;
   assign d_valid = done && state == BUSY_D;
   assign i_rdata = i_valid ? readData : '0;
   assign d_rdata = d_valid ? readData : '0;
   assign stall_f = i_req && !i_valid;
   assign stall_m = d_req && !d_valid;
   assign mem_req = busy;
   assign mem_we = busy && heldWe;
   assign mem_addr = heldAddr;
   assign mem_wdata = heldWdata;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         streak <= '0;
         heldWe <= 1'b0;
         heldAddr <= '0;
         heldWdata <= '0;
      end else if (busy) begin
         if (done) state <= IDLE;
      end else if (grantD || grantI) begin
         state <= grantD ? BUSY_D : BUSY_I;
         streak <= grantD && i_req ? streak + 1'b1 : '0;
         heldWe <= grantD && d_we;
         heldAddr <= grantD ? d_addr : i_addr;
         heldWdata <= grantD ? d_wdata : '0;
      end
`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] waitCnt;
   logic errFlag;
   assign abort = busy && !mem_ready && waitCnt == TW'(TIMEOUT_CYCLES - 1);
   assign err = errFlag;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         waitCnt <= '0;
         errFlag <= 1'b0;
      end else begin
         waitCnt <= !busy ? '0 : !mem_ready ? waitCnt + 1'b1 : waitCnt;
         if (abort) errFlag <= 1'b1;
      end
`else
   assign abort = 1'b0;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios plus random traffic against a transaction-level arbiter model.
module tb_unified_mem_arbiter;
   localparam int LIMIT = 4, TO = 16;
   logic clk = 1'b0, reset = 1'b1;
   logic iReq = 1'b0, dReq = 1'b0, dWe = 1'b0, memReady = 1'b0;
   logic [31:0] iAddr = '0, dAddr = '0, dWdata = '0, memRdata = '0;
   logic [31:0] iRdata, dRdata, memAddr, memWdata;
   logic iValid, dValid, stallF, stallM, memReq, memWe, err;
   int checks = 0, errors = 0, run;
   bit mBusy, mPortD, mWe, mErr, lastI, lastD;
   logic [31:0] mAddr, mWdata;
   int mStreak, mAge;

   unified_mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .i_req(iReq), .i_addr(iAddr), .i_rdata(iRdata), .i_valid(iValid),
      .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_rdata(dRdata), .d_valid(dValid),
      .stall_f(stallF), .stall_m(stallM), .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ready(memReady), .err(err));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mBusy = 0; mPortD = 0; mWe = 0; mErr = 0; mAddr = '0; mWdata = '0; mStreak = 0; mAge = 0;
   endtask

   // Compare one cycle against the model, then advance the model across the rising edge
   task automatic tick();
      bit done, timeoutHit, expI, expD;
      logic [31:0] rd;
      timeoutHit = 0;
`ifdef ARB_TIMEOUT_EN
      timeoutHit = mBusy && !memReady && mAge == TO - 1;
`endif
      done = mBusy && (memReady || timeoutHit);
      expI = done && !mPortD;
      expD = done && mPortD;
      rd = memReady ? memRdata : 32'h0;
      #3;
      check("mem_req", 32'(memReq), 32'(mBusy));
      if (mBusy) begin
         check("mem_we", 32'(memWe), 32'(mWe));
         check("mem_addr", memAddr, mAddr);
         check("mem_wdata", memWdata, mWdata);
      end
      check("i_valid", 32'(iValid), 32'(expI));
      check("d_valid", 32'(dValid), 32'(expD));
      check("i_rdata", iRdata, expI ? rd : 32'h0);
      check("d_rdata", dRdata, expD ? rd : 32'h0);
      check("stall_f", 32'(stallF), 32'(iReq && !expI));
      check("stall_m", 32'(stallM), 32'(dReq && !expD));
      check("err", 32'(err), 32'(mErr));
      lastI = expI;
      lastD = expD;
      @(posedge clk);
      if (mBusy) begin
         if (done) begin
            mBusy = 0;
            if (timeoutHit) mErr = 1;
         end else mAge++;
      end else if (dReq && (!iReq || mStreak < LIMIT)) begin
         mBusy = 1; mPortD = 1; mWe = dWe; mAddr = dAddr; mWdata = dWdata; mAge = 0;
         mStreak = iReq ? mStreak + 1 : 0;
      end else if (iReq) begin
         mBusy = 1; mPortD = 0; mWe = 0; mAddr = iAddr; mWdata = '0; mAge = 0; mStreak = 0;
      end
      #1;
   endtask

   task automatic doReset();
      iReq = 0; dReq = 0; dWe = 0; memReady = 0;
      reset = 1;
      modelReset();
      @(posedge clk);
      #1 reset = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      modelReset();
      #1;
      check("rst_mem_req", 32'(memReq), 0);
      check("rst_valids", 32'({iValid, dValid}), 0);
      check("rst_rdata", iRdata | dRdata, 0);
      check("rst_err", 32'(err), 0);
      @(posedge clk);
      #1 reset = 0;

      // fetch only
      doReset();
      iReq = 1; iAddr = 32'h10; memReady = 1; memRdata = 32'hE3A01005;
      #2 check("fo_stall0", 32'(stallF), 1);
      check("fo_req0", 32'(memReq), 0);
      tick();
      #2 check("fo_addr", memAddr, 32'h10);
      check("fo_we", 32'(memWe), 0);
      check("fo_valid", 32'(iValid), 1);
      check("fo_rdata", iRdata, 32'hE3A01005);
      check("fo_stall1", 32'(stallF), 0);
      tick();
      iReq = 0; memReady = 0;
      tick();

      // simultaneous requests
      doReset();
      iReq = 1; iAddr = 32'h20; dReq = 1; dWe = 1; dAddr = 32'h100; dWdata = 32'hDEADBEEF; memReady = 1;
      tick();
      #2 check("sim_we", 32'(memWe), 1);
      check("sim_addr", memAddr, 32'h100);
      check("sim_wdata", memWdata, 32'hDEADBEEF);
      check("sim_dvalid", 32'(dValid), 1);
      check("sim_stallf", 32'(stallF), 1);
      tick();
      dReq = 0; dWe = 0;
      tick();
      #2 check("sim_ivalid", 32'(iValid), 1);
      check("sim_iaddr", memAddr, 32'h20);
      tick();
      iReq = 0;
      tick();

      // starvation guard
      doReset();
      iReq = 1; dReq = 1; memReady = 1; run = 0;
      for (int c = 0; c < 40; c++) begin
         iAddr = $urandom; dAddr = $urandom; dWdata = $urandom; dWe = 1'($urandom_range(0, 1)); memRdata = $urandom;
         #2;
         if (dValid) run++;
         if (iValid) begin
            check("starve_run", run, LIMIT);
            run = 0;
         end
         tick();
      end

      // wait states with moving requester address
      doReset();
      dReq = 1; dAddr = 32'h40; memReady = 0;
      tick();
      for (int c = 0; c < 3; c++) begin
         dAddr = $urandom;
         #2 check("ws_addr", memAddr, 32'h40);
         tick();
      end
      memReady = 1; memRdata = 32'h12345678; dAddr = $urandom;
      #2 check("ws_valid", 32'(dValid), 1);
      check("ws_rdata", dRdata, 32'h12345678);
      check("ws_addr4", memAddr, 32'h40);
      tick();
      dReq = 0; memReady = 0;
      tick();

      // asynchronous reset during a wait
      doReset();
      dReq = 1; dAddr = 32'h80;
      tick();
      #2 check("ar_busy", 32'(memReq), 1);
      reset = 1; dReq = 0;
      #1 check("ar_req", 32'(memReq), 0);
      check("ar_stall", 32'(stallM), 0);
      check("ar_valid", 32'(dValid), 0);
      modelReset();
      @(posedge clk);
      #1 reset = 0;
      #2 check("ar_idle", 32'(memReq), 0);
      tick();

      // memory that never answers
      doReset();
      dReq = 1; dAddr = $urandom; memRdata = 32'hA5A5A5A5;
      tick();
      for (int c = 1; c <= TO; c++) begin
         #2;
`ifdef ARB_TIMEOUT_EN
         check("to_valid", 32'(dValid), 32'(c == TO));
         if (c == TO) check("to_rdata", dRdata, 0);
`else
         check("to_stall", 32'(stallM), 1);
`endif
         check("to_err", 32'(err), 0);
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      dReq = 0;
      #2 check("to_err_set", 32'(err), 1);
      tick();
      tick();
      #2 check("to_err_sticky", 32'(err), 1);
`else
      #2 check("to_err_off", 32'(err), 0);
      check("to_still_busy", 32'(memReq), 1);
`endif

      // random traffic; requests held until their valid
      doReset();
      lastI = 0; lastD = 0;
      for (int c = 0; c < 400; c++) begin
         if (!iReq || lastI) iReq = $urandom_range(0, 2) != 0;
         if (!dReq || lastD) dReq = $urandom_range(0, 2) != 0;
         iAddr = $urandom; dAddr = $urandom; dWdata = $urandom; dWe = 1'($urandom_range(0, 1));
         memReady = 1'($urandom_range(0, 1)); memRdata = $urandom;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
